// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Top-level frame controller for the convolution pipeline. One frame runs:
//   clear the sub-blocks, load the image, load the kernel, run the GeMM engine,
//   stream the results out over UART, then return to idle.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : asynchronous active-low reset
//   go             : frame request (sampled in IDLE and ERR only)
//   abort          : synchronous abort of the frame in progress
//   img_load_done  : image BRAM fully written (level)
//   ker_load_done  : kernel registers loaded (level)
//   compute_done   : GeMM engine finished (level)
//   read_done      : UART reader finished (level)
//   sub_rst        : active-high reset to loaders, engine and reader
//   img_load_en    : image loader enable
//   ker_load_en    : kernel loader enable
//   compute_start  : 1-cycle engine start pulse
//   read_start     : 1-cycle reader start pulse
//   bram_sel       : output BRAM owner (0 none, 1 engine, 2 reader)
//   busy           : frame in progress
//   frame_done     : 1-cycle pulse per completed frame
//   error          : sticky watchdog error
//   frame_count    : completed frames, modulo 256
//
// Configuration
//   SEQ_WATCHDOG_EN : when defined, a per-state watchdog of TIMEOUT_CYCLES clk
//                     cycles sends a stalled frame to ERR. When undefined, ERR
//                     is unreachable and error is tied low.

module conv_frame_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       abort,
  input  logic       img_load_done,
  input  logic       ker_load_done,
  input  logic       compute_done,
  input  logic       read_done,
  output logic       sub_rst,
  output logic       img_load_en,
  output logic       ker_load_en,
  output logic       compute_start,
  output logic       read_start,
  output logic [1:0] bram_sel,
  output logic       busy,
  output logic       frame_done,
  output logic       error,
  output logic [7:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_IMG,
    S_LOAD_KER,
    S_COMPUTE,
    S_READOUT,
    S_DONE,
    S_ERR
  } state_e;

  state_e     state_q, state_d;
  logic       timeout;

  logic       sub_rst_q;
  logic       img_load_en_q;
  logic       ker_load_en_q;
  logic       compute_start_q;
  logic       read_start_q;
  logic [1:0] bram_sel_q;
  logic       busy_q;
  logic       frame_done_q;
  logic [7:0] frame_count_q;

`ifdef SEQ_WATCHDOG_EN
  logic [23:0] wd_q;
  logic        error_q;

  // Counter restarts on every state change; it only advances in the busy
  // states, so IDLE/DONE/ERR never trip it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (state_q inside {S_CLEAR, S_LOAD_IMG, S_LOAD_KER, S_COMPUTE, S_READOUT}) begin
      wd_q <= wd_q + 24'd1;
    end
  end

  assign timeout = (wd_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_d == S_ERR);
    end
  end

  assign error = error_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // Abort outranks the done inputs, and both outrank the watchdog. Done inputs
  // are only looked at while already in the state, so a done that is high on
  // entry still leaves the state one full cycle (start pulse always issued).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (go) state_d = S_CLEAR;
      S_CLEAR:    state_d = abort ? S_IDLE : S_LOAD_IMG;
      S_LOAD_IMG: begin
        if (abort)              state_d = S_IDLE;
        else if (img_load_done) state_d = S_LOAD_KER;
        else if (timeout)       state_d = S_ERR;
      end
      S_LOAD_KER: begin
        if (abort)              state_d = S_IDLE;
        else if (ker_load_done) state_d = S_COMPUTE;
        else if (timeout)       state_d = S_ERR;
      end
      S_COMPUTE: begin
        if (abort)             state_d = S_IDLE;
        else if (compute_done) state_d = S_READOUT;
        else if (timeout)      state_d = S_ERR;
      end
      S_READOUT: begin
        if (abort)          state_d = S_IDLE;
        else if (read_done) state_d = S_DONE;
        else if (timeout)   state_d = S_ERR;
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR:      if (go) state_d = S_CLEAR;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // without a decode stage; bram_sel therefore switches 1 -> 2 in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      sub_rst_q       <= 1'b1;
      img_load_en_q   <= 1'b0;
      ker_load_en_q   <= 1'b0;
      compute_start_q <= 1'b0;
      read_start_q    <= 1'b0;
      bram_sel_q      <= 2'd0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      sub_rst_q       <= (state_d == S_CLEAR);
      img_load_en_q   <= (state_d == S_LOAD_IMG);
      ker_load_en_q   <= (state_d == S_LOAD_KER);
      compute_start_q <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
      read_start_q    <= (state_d == S_READOUT) && (state_q != S_READOUT);
      bram_sel_q      <= (state_d == S_COMPUTE) ? 2'd1 :
                         (state_d == S_READOUT) ? 2'd2 : 2'd0;
      busy_q          <= state_d inside {S_CLEAR, S_LOAD_IMG, S_LOAD_KER,
                                         S_COMPUTE, S_READOUT};
      frame_done_q    <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign sub_rst       = sub_rst_q;
  assign img_load_en   = img_load_en_q;
  assign ker_load_en   = ker_load_en_q;
  assign compute_start = compute_start_q;
  assign read_start    = read_start_q;
  assign bram_sel      = bram_sel_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer
//   Directed bench for conv_frame_sequencer. Outputs are packed into one
//   vector and compared against hand-written per-state constants.
//   Watchdog expectations follow SEQ_WATCHDOG_EN.

module tb_conv_frame_sequencer;

  logic       clk;
  logic       reset;
  logic       go, abort;
  logic       img_load_done, ker_load_done, compute_done, read_done;
  logic       sub_rst, img_load_en, ker_load_en, compute_start, read_start;
  logic [1:0] bram_sel;
  logic       busy, frame_done, error;
  logic [7:0] frame_count;

  int unsigned total_cnt;
  int unsigned pass_cnt;
  int unsigned fd_cnt;

  conv_frame_sequencer #(
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .go            (go),
    .abort         (abort),
    .img_load_done (img_load_done),
    .ker_load_done (ker_load_done),
    .compute_done  (compute_done),
    .read_done     (read_done),
    .sub_rst       (sub_rst),
    .img_load_en   (img_load_en),
    .ker_load_en   (ker_load_en),
    .compute_start (compute_start),
    .read_start    (read_start),
    .bram_sel      (bram_sel),
    .busy          (busy),
    .frame_done    (frame_done),
    .error         (error),
    .frame_count   (frame_count)
  );

  // {busy, sub_rst, img_en, ker_en, bram_sel[1:0], cstart, rstart, fdone, error, 0}
  logic [10:0] vec;
  assign vec = {busy, sub_rst, img_load_en, ker_load_en, bram_sel,
                compute_start, read_start, frame_done, error, 1'b0};

  localparam logic [10:0] V_IDLE  = 11'h000;
  localparam logic [10:0] V_RST   = 11'h200;
  localparam logic [10:0] V_CLEAR = 11'h600;
  localparam logic [10:0] V_LIMG  = 11'h500;
  localparam logic [10:0] V_LKER  = 11'h480;
  localparam logic [10:0] V_COMP0 = 11'h430;
  localparam logic [10:0] V_COMP  = 11'h420;
  localparam logic [10:0] V_READ0 = 11'h448;
  localparam logic [10:0] V_READ  = 11'h440;
  localparam logic [10:0] V_DONE  = 11'h004;
`ifdef SEQ_WATCHDOG_EN
  localparam logic [10:0] V_WD    = 11'h002;
`else
  localparam logic [10:0] V_WD    = V_READ;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry-cycle check followed by four more cycles in the same state.
  task automatic dwell(input string tag, input logic [10:0] first, input logic [10:0] rest);
    check(tag, 32'(vec), 32'(first));
    repeat (4) begin
      tick();
      check(tag, 32'(vec), 32'(rest));
    end
  endtask

  task automatic clear_dones();
    img_load_done = 1'b0;
    ker_load_done = 1'b0;
    compute_done  = 1'b0;
    read_done     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    reset = 1'b0;
    go    = 1'b0;
    abort = 1'b0;
    clear_dones();

    // Reset state
    #12;
    check("rst_vec", 32'(vec), 32'(V_RST));
    check("rst_fc", 32'(frame_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rel_idle", 32'(vec), 32'(V_IDLE));

    // Normal frame, dones raised after 5 cycles; go while busy ignored
    go = 1'b1;
    tick();
    go = 1'b0;
    check("n_clear", 32'(vec), 32'(V_CLEAR));
    tick();
    dwell("n_limg", V_LIMG, V_LIMG);
    img_load_done = 1'b1;
    tick();
    go = 1'b1;
    dwell("n_lker", V_LKER, V_LKER);
    go = 1'b0;
    ker_load_done = 1'b1;
    tick();
    dwell("n_comp", V_COMP0, V_COMP);
    compute_done = 1'b1;
    tick();
    dwell("n_read", V_READ0, V_READ);
    read_done = 1'b1;
    tick();
    check("n_done", 32'(vec), 32'(V_DONE));
    check("n_fc", 32'(frame_count), 32'd1);
    tick();
    check("n_idle", 32'(vec), 32'(V_IDLE));
    clear_dones();
    tick();
    check("n_stay", 32'(vec), 32'(V_IDLE));

    // Pre-asserted dones: one cycle per state, 7 cycles go -> IDLE
    img_load_done = 1'b1;
    ker_load_done = 1'b1;
    compute_done  = 1'b1;
    read_done     = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("p_clear", 32'(vec), 32'(V_CLEAR));
    tick(); check("p_limg", 32'(vec), 32'(V_LIMG));
    tick(); check("p_lker", 32'(vec), 32'(V_LKER));
    tick(); check("p_comp", 32'(vec), 32'(V_COMP0));
    tick(); check("p_read", 32'(vec), 32'(V_READ0));
    tick(); check("p_done", 32'(vec), 32'(V_DONE));
    check("p_fc", 32'(frame_count), 32'd2);
    tick(); check("p_idle", 32'(vec), 32'(V_IDLE));
    clear_dones();

    // Abort together with compute_done in COMPUTE
    img_load_done = 1'b1;
    ker_load_done = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    check("a_comp", 32'(vec), 32'(V_COMP0));
    abort = 1'b1;
    compute_done = 1'b1;
    tick();
    abort = 1'b0;
    check("a_idle", 32'(vec), 32'(V_IDLE));
    check("a_fc", 32'(frame_count), 32'd2);
    tick();
    check("a_noread", 32'(vec), 32'(V_IDLE));
    clear_dones();

    // Reset mid LOAD_KER
    img_load_done = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    check("r_lker", 32'(vec), 32'(V_LKER));
    #2;
    reset = 1'b0;
    #1;
    check("r_async", 32'(vec), 32'(V_RST));
    check("r_fc", 32'(frame_count), 32'd0);
    tick();
    check("r_hold", 32'(vec), 32'(V_RST));
    reset = 1'b1;
    clear_dones();
    tick();
    check("r_idle", 32'(vec), 32'(V_IDLE));

    // 256 back-to-back frames: frame_count wraps to 0
    img_load_done = 1'b1;
    ker_load_done = 1'b1;
    compute_done  = 1'b1;
    read_done     = 1'b1;
    go = 1'b1;
    fd_cnt = 0;
    repeat (255 * 7) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    check("w_fc255", 32'(frame_count), 32'd255);
    repeat (7) begin
      tick();
      if (frame_done) fd_cnt++;
    end
    go = 1'b0;
    check("w_fc0", 32'(frame_count), 32'd0);
    check("w_pulses", fd_cnt, 32'd256);
    tick();
    check("w_idle", 32'(vec), 32'(V_IDLE));
    clear_dones();

    // Watchdog: read_done held low in READOUT
    img_load_done = 1'b1;
    ker_load_done = 1'b1;
    compute_done  = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick(); tick();
    check("wd_entry", 32'(vec), 32'(V_READ0));
    clear_dones();
    repeat (99) tick();
    check("wd_99", 32'(vec), 32'(V_READ));
    tick();
    check("wd_100", 32'(vec), 32'(V_WD));
`ifdef SEQ_WATCHDOG_EN
    tick();
    check("wd_sticky", 32'(vec), 32'(V_WD));
    go = 1'b1;
    tick();
    go = 1'b0;
    check("wd_clear", 32'(vec), 32'(V_CLEAR));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wd_idle", 32'(vec), 32'(V_IDLE));
`else
    read_done = 1'b1;
    tick();
    check("wd_done", 32'(vec), 32'(V_DONE));
    tick();
    check("wd_idle", 32'(vec), 32'(V_IDLE));
    clear_dones();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd16777215, per-state watchdog limit in clk cycles.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset of the whole block.
REQ-004 go  input  1  frame request; sampled in IDLE and ERR only.
REQ-005 abort  input  1  synchronous abort of the frame in progress.
REQ-006 img_load_done  input  1  level; image BRAM fully written by UART loader.
REQ-007 ker_load_done  input  1  level; kernel registers fully loaded.
REQ-008 compute_done  input  1  level; GeMM engine finished writing output BRAM.
REQ-009 read_done  input  1  level; UART BRAM reader has sent all 49284 results.
REQ-010 sub_rst  output  1  active-high reset to loaders, engine and reader.
REQ-011 img_load_en, ker_load_en  output  1 each  loader enables.
REQ-012 compute_start, read_start  output  1 each  single-cycle start pulses.
REQ-013 bram_sel  output  2  output-BRAM port owner: 0 = none, 1 = engine, 2 = reader.
REQ-014 busy, frame_done, error  output  1 each  status; frame_done is a 1-cycle pulse.
REQ-015 frame_count  output  8  completed frames.

Function
REQ-016 States SHALL be IDLE, CLEAR, LOAD_IMG, LOAD_KER, COMPUTE, READOUT, DONE, ERR; all outputs registered, decoded from the state.
REQ-017 IDLE: go=1 -> CLEAR next cycle; otherwise hold IDLE.
REQ-018 CLEAR: exactly one cycle with sub_rst=1, then LOAD_IMG; this also clears a reader latched in its terminal state.
REQ-019 LOAD_IMG: img_load_en=1; img_load_done=1 -> LOAD_KER.
REQ-020 LOAD_KER: ker_load_en=1; ker_load_done=1 -> COMPUTE.
REQ-021 COMPUTE: bram_sel=1; compute_start=1 only in the first cycle after entry; compute_done=1 -> READOUT.
REQ-022 READOUT: bram_sel=2; read_start=1 only in the first cycle after entry; read_done=1 -> DONE.
REQ-023 A done input already high on state entry SHALL advance the state no earlier than the cycle after entry, so each start pulse is always issued.
REQ-024 DONE: one cycle; frame_done=1; frame_count increments modulo 256 (255 -> 0); then IDLE.
REQ-025 busy=1 in every state except IDLE, DONE and ERR.
REQ-026 bram_sel SHALL be 0 in every state except COMPUTE and READOUT; a BRAM-ownership change SHALL always pass through a state with a defined owner, never one cycle at an undefined value.
REQ-027 abort=1 in CLEAR through READOUT -> IDLE next cycle. abort takes priority over any simultaneous done input. frame_count is unchanged.
REQ-028 go while busy=1 SHALL be ignored.

Reset
REQ-029 reset=0 SHALL force IDLE immediately.
REQ-030 On reset=0, all outputs SHALL be 0, including frame_count; the exception is sub_rst, which SHALL be 1.
REQ-031 Reset mid-frame SHALL discard the frame with no frame_done pulse.
REQ-032 The first clock edge after reset release SHALL take sub_rst to 0.

Configuration
REQ-033 Macro SEQ_WATCHDOG_EN defined: a 24-bit counter clears on every state entry and increments each cycle in CLEAR..READOUT.
REQ-034 With SEQ_WATCHDOG_EN defined, the counter reaching TIMEOUT_CYCLES-1 without the exit condition -> ERR. In ERR: error=1 sticky; go=1 -> CLEAR and error returns to 0; abort takes priority over timeout in the same cycle.
REQ-035 Macro SEQ_WATCHDOG_EN undefined: no counter and ERR unreachable; error is tied to 0; all other behaviour is identical.

Verification
REQ-036 Normal frame. go pulse, then each done input raised 5 cycles after its enable or start. Required: states in order CLEAR, LOAD_IMG, LOAD_KER, COMPUTE, READOUT, DONE, IDLE; one compute_start and one read_start; frame_done once; frame_count 0 -> 1.
REQ-037 Pre-asserted done. All done inputs held at 1 before go. Required: each state lasts exactly one cycle; compute_start=1 and read_start=1 each for exactly one cycle; 7 cycles from go to IDLE.
REQ-038 Abort in COMPUTE. abort=1 and compute_done=1 in the same cycle. Required: IDLE next cycle; bram_sel=0; no read_start; frame_count unchanged.
REQ-039 Counter wrap. 256 back-to-back frames. Required: frame_count returns to 0; 256 frame_done pulses.
REQ-040 Watchdog (SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=100). read_done held at 0. Required: ERR exactly 100 cycles after READOUT entry; error=1; busy=0; a following go -> CLEAR with error=0.
REQ-041 Reset mid-frame. reset=0 mid-LOAD_KER. Required: IDLE immediately; all outputs 0 except sub_rst=1; no frame_done.
